// File: rtl/cfi_landing_monitor_pkg.sv
// -----------------------------------------------------------------------------
// cfi_landing_monitor_pkg
//   Shared types for the control-flow-integrity landing monitor.
//   - fu_t / scoreboard_entry_t : the subset of a commit-stage scoreboard entry
//                                 the monitor looks at (pc, fu, is_compressed)
//   - exception_t               : exception record handed to the commit stage
//   - cfi_mode_e                : CSR mode encoding
//   - cfi_state_e               : monitor FSM states
//   - fall_through()            : sequential successor PC of an instruction
// -----------------------------------------------------------------------------
package cfi_landing_monitor_pkg;

    localparam int unsigned VLEN = 64;
    localparam int unsigned XLEN = 64;

    typedef enum logic [3:0] {
        NONE,
        LOAD,
        STORE,
        ALU,
        CTRL_FLOW,
        MULT,
        CSR
    } fu_t;

    typedef struct packed {
        logic [VLEN-1:0] pc;
        fu_t             fu;
        logic            is_compressed;
    } scoreboard_entry_t;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;

    typedef enum logic [1:0] {
        CFI_OFF     = 2'b00,
        CFI_COUNT   = 2'b01,
        CFI_ENFORCE = 2'b10,
        CFI_LOCK    = 2'b11
    } cfi_mode_e;

    typedef enum logic [1:0] {
        CFI_IDLE   = 2'b00,
        CFI_EXPECT = 2'b01,
        CFI_TRAP   = 2'b10
    } cfi_state_e;

    localparam logic [6:0]      CFI_MARKER_OPCODE = 7'b0010011;
    localparam logic [XLEN-1:0] CFI_CAUSE         = 64'd24;

    // Wraps modulo 2^VLEN by construction of the result width.
    function automatic logic [VLEN-1:0] fall_through(input logic [VLEN-1:0] pc,
                                                     input logic            is_compressed);
        return pc + (is_compressed ? VLEN'(2) : VLEN'(4));
    endfunction

endpackage

// File: rtl/cfi_marker_decode.sv
// -----------------------------------------------------------------------------
// cfi_marker_decode
//   Recognises the landing marker: ADDI x0,x0,imm with imm[11:4] == LABEL_TAG.
//   Ports:
//     instr     in  32  raw instruction word
//     is_marker out 1   word is a valid landing marker
//   Purely combinational. imm[3:0] (bits 23:20) is free for software use.
// -----------------------------------------------------------------------------
module cfi_marker_decode
    import cfi_landing_monitor_pkg::*;
#(
    parameter logic [7:0] LABEL_TAG = 8'hA5
) (
    input  logic [31:0] instr,
    output logic        is_marker
);

    logic unused_imm_low;
    assign unused_imm_low = ^instr[23:20];

    assign is_marker = (instr[6:0]   == CFI_MARKER_OPCODE) &&
                       (instr[11:7]  == 5'd0) &&
                       (instr[14:12] == 3'd0) &&
                       (instr[19:15] == 5'd0) &&
                       (instr[31:24] == LABEL_TAG);

endmodule

// File: rtl/cfi_landing_monitor.sv
// -----------------------------------------------------------------------------
// cfi_landing_monitor
//   Commit-stream monitor: every taken control-flow transfer must land on a
//   marker NOP. Counts violations, drives debug LEDs and, in enforce modes,
//   raises an exception towards the commit stage.
//   Ports:
//     clk_i, rst_i       clock, synchronous active-high reset
//     flush_i            pipeline flush; drops any pending source
//     mode_i             00 off, 01 count, 10 enforce, 11 enforce+lock
//     commit_instr_i     per-port commit candidates (pc, fu, is_compressed)
//     instr_bits_i       per-port raw instruction words
//     commit_ack_i       per-port retire strobe, contiguous from port 0
//     ex_ack_i           commit stage has taken the exception
//     exception_o        violation exception (valid, cause, tval)
//     viol_cnt_o         saturating violation count
//     locked_o           sticky lock flag
//     leds_o             {locked, state==TRAP, state==EXPECT, viol_cnt[0]}
//
//   Exception handshake: exception_o.valid rises the cycle after a violation is
//   detected and stays high while ex_ack_i is low; a cycle with ex_ack_i high
//   is the acceptance, and valid is low from the following cycle.
// -----------------------------------------------------------------------------
module cfi_landing_monitor
    import cfi_landing_monitor_pkg::*;
#(
    parameter int unsigned     NR_COMMIT_PORTS = 2,
    parameter logic [7:0]      LABEL_TAG       = 8'hA5,
    parameter int unsigned     CNT_W           = 16,
    parameter logic [XLEN-1:0] CAUSE           = CFI_CAUSE
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic [1:0]        mode_i,
    input  scoreboard_entry_t commit_instr_i [NR_COMMIT_PORTS],
    input  logic [31:0]       instr_bits_i   [NR_COMMIT_PORTS],
    input  logic [NR_COMMIT_PORTS-1:0] commit_ack_i,
    input  logic              ex_ack_i,
    output exception_t        exception_o,
    output logic [CNT_W-1:0]  viol_cnt_o,
    output logic              locked_o,
    output logic [3:0]        leds_o
);

    cfi_state_e              state_q, state_d;
    logic [VLEN-1:0]         saved_pc_q;
    logic                    saved_c_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    locked_q;
    logic [XLEN-1:0]         cause_q;
    logic [XLEN-1:0]         tval_q;

    logic [NR_COMMIT_PORTS-1:0] is_marker;

    for (genvar g = 0; g < NR_COMMIT_PORTS; g++) begin : g_dec
        cfi_marker_decode #(.LABEL_TAG(LABEL_TAG)) u_dec (
            .instr     (instr_bits_i[g]),
            .is_marker (is_marker[g])
        );
    end

    // Once locked, the monitor behaves as enforce+lock regardless of the CSR.
    logic [1:0] eff_mode;
    assign eff_mode = locked_q ? CFI_LOCK : mode_i;

    // Port scan. src_* walks along the acked ports: it starts as the pending
    // source from the previous cycle and is replaced by every acked port, so
    // after the loop it describes the last acked instruction.
    logic            src_v;
    logic [VLEN-1:0] src_pc;
    logic            src_c;
    logic            any_ack;
    logic            chain;
    logic            viol_found;
    logic [VLEN-1:0] viol_pc;

    always_comb begin
        src_v      = (state_q == CFI_EXPECT);
        src_pc     = saved_pc_q;
        src_c      = saved_c_q;
        any_ack    = 1'b0;
        chain      = 1'b1;
        viol_found = 1'b0;
        viol_pc    = '0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (chain && commit_ack_i[i]) begin
                any_ack = 1'b1;
                if (src_v && !viol_found && !is_marker[i] &&
                    (commit_instr_i[i].pc != fall_through(src_pc, src_c))) begin
                    viol_found = 1'b1;
                    viol_pc    = commit_instr_i[i].pc;
                end
                src_v  = (commit_instr_i[i].fu == CTRL_FLOW);
                src_pc = commit_instr_i[i].pc;
                src_c  = commit_instr_i[i].is_compressed;
            end else begin
                chain = 1'b0;
            end
        end
    end

    // Squashed instructions never count, and mode 00 disables detection.
    logic viol;
    logic trap_req;
    assign viol     = viol_found && (eff_mode != CFI_OFF) && !flush_i;
    assign trap_req = viol && eff_mode[1];

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CFI_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = (state_q == CFI_TRAP && !ex_ack_i) ? CFI_TRAP : CFI_IDLE;
        end else if (trap_req) begin
            state_d = CFI_TRAP;
        end else if (state_q == CFI_TRAP) begin
            state_d = ex_ack_i ? CFI_IDLE : CFI_TRAP;
        end else if (eff_mode == CFI_OFF) begin
            state_d = CFI_IDLE;
        end else if (any_ack) begin
            state_d = src_v ? CFI_EXPECT : CFI_IDLE;
        end
    end

    // FSM: outputs
    always_comb begin
        exception_o.valid = (state_q == CFI_TRAP);
        exception_o.cause = cause_q;
        exception_o.tval  = tval_q;
        leds_o            = {locked_q, state_q == CFI_TRAP, state_q == CFI_EXPECT, cnt_q[0]};
    end

    assign viol_cnt_o = cnt_q;
    assign locked_o   = locked_q;

    // Datapath: pending source, counter, lock and exception payload.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            saved_pc_q <= '0;
            saved_c_q  <= 1'b0;
            cnt_q      <= '0;
            locked_q   <= 1'b0;
            cause_q    <= '0;
            tval_q     <= '0;
        end else begin
            if (state_d == CFI_EXPECT && any_ack) begin
                saved_pc_q <= src_pc;
                saved_c_q  <= src_c;
            end
            if (viol && cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (viol && eff_mode == CFI_LOCK) begin
                locked_q <= 1'b1;
            end
            if (trap_req) begin
                cause_q <= CAUSE;
                tval_q  <= XLEN'(viol_pc);
            end
        end
    end

endmodule

// File: tb/tb_cfi_landing_monitor.sv
// -----------------------------------------------------------------------------
// tb_cfi_landing_monitor
//   Directed bench. dut uses default parameters; dut4 (CNT_W=4) shares the same
//   stimulus and is only inspected for counter saturation and reset values.
// -----------------------------------------------------------------------------
module tb_cfi_landing_monitor;
    import cfi_landing_monitor_pkg::*;

    localparam int unsigned NP = 2;
    localparam logic [31:0] MARKER = 32'hA500_0013; // ADDI x0,x0,0xA50
    localparam logic [31:0] ADD    = 32'h0031_00B3; // ADD x1,x2,x3

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [1:0]        mode;
    scoreboard_entry_t commit_instr [NP];
    logic [31:0]       instr_bits   [NP];
    logic [NP-1:0]     commit_ack;
    logic              ex_ack;

    exception_t        exc;
    logic [15:0]       cnt;
    logic              locked;
    logic [3:0]        leds;
    exception_t        exc4;
    logic [3:0]        cnt4;
    logic              locked4;
    logic [3:0]        leds4;

    logic [63:0] exp_q[$];
    int          cmp_cnt  = 0;
    int          fail_cnt = 0;

    always #5 clk = ~clk;

    cfi_landing_monitor #(.NR_COMMIT_PORTS(NP)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .mode_i(mode),
        .commit_instr_i(commit_instr), .instr_bits_i(instr_bits),
        .commit_ack_i(commit_ack), .ex_ack_i(ex_ack),
        .exception_o(exc), .viol_cnt_o(cnt), .locked_o(locked), .leds_o(leds)
    );

    cfi_landing_monitor #(.NR_COMMIT_PORTS(NP), .CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .mode_i(mode),
        .commit_instr_i(commit_instr), .instr_bits_i(instr_bits),
        .commit_ack_i(commit_ack), .ex_ack_i(ex_ack),
        .exception_o(exc4), .viol_cnt_o(cnt4), .locked_o(locked4), .leds_o(leds4)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        commit_ack = '0;
        flush      = 1'b0;
        ex_ack     = 1'b0;
        for (int i = 0; i < NP; i++) begin
            commit_instr[i] = '{pc: '0, fu: NONE, is_compressed: 1'b0};
            instr_bits[i]   = 32'h0000_0013;
        end
    endtask

    task automatic set_port(input int p, input logic [63:0] pc, input fu_t fu,
                            input logic c, input logic [31:0] bits);
        commit_instr[p] = '{pc: pc, fu: fu, is_compressed: c};
        instr_bits[p]   = bits;
        commit_ack[p]   = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic push(input logic [63:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs);
        logic [63:0] e;
        cmp_cnt++;
        if (exp_q.size() == 0) begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                fail_cnt++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
            end
        end
    endtask

    initial begin
        mode = 2'b00;
        do_reset();

        // Reset state
        push(0); chk("rst_valid", 64'(exc.valid));
        push(0); chk("rst_cause", exc.cause);
        push(0); chk("rst_tval", exc.tval);
        push(0); chk("rst_cnt", 64'(cnt));
        push(0); chk("rst_locked", 64'(locked));
        push(0); chk("rst_leds", 64'(leds));
        push(0); chk("rst_cnt4", 64'(cnt4));
        push(0); chk("rst_locked4", 64'(locked4));

        // Marker hit inside one cycle
        mode = 2'b10;
        set_port(0, 64'h8000_0000, CTRL_FLOW, 1'b0, 32'h1000_006F);
        set_port(1, 64'h8000_0100, ALU, 1'b0, MARKER);
        push(0); push(0); push(0);
        cycle();
        chk("hit_valid", 64'(exc.valid));
        chk("hit_cnt", 64'(cnt));
        chk("hit_leds", 64'(leds));

        // Missing marker across a cycle boundary
        do_reset();
        mode = 2'b10;
        set_port(0, 64'h1000, CTRL_FLOW, 1'b0, 32'h0000_8067);
        push(4'b0010);
        cycle();
        chk("xc_expect_leds", 64'(leds));
        idle();
        set_port(0, 64'h2000, ALU, 1'b0, ADD);
        push(1); push(24); push(64'h2000); push(1); push(4'b0101);
        cycle();
        chk("xc_valid", 64'(exc.valid));
        chk("xc_cause", exc.cause);
        chk("xc_tval", exc.tval);
        chk("xc_cnt", 64'(cnt));
        chk("xc_leds", 64'(leds));
        idle();
        push(1);
        cycle();
        chk("xc_hold", 64'(exc.valid));
        ex_ack = 1'b1;
        push(0); push(4'b0001);
        cycle();
        chk("xc_after_ack", 64'(exc.valid));
        chk("xc_after_ack_leds", 64'(leds));
        idle();

        // Compressed branch: fall-through is pc+2
        do_reset();
        mode = 2'b10;
        set_port(0, 64'h1000, CTRL_FLOW, 1'b1, 32'h0000_C001);
        set_port(1, 64'h1002, ALU, 1'b0, ADD);
        push(0); push(0);
        cycle();
        chk("nt_valid", 64'(exc.valid));
        chk("nt_cnt", 64'(cnt));
        set_port(1, 64'h1004, ALU, 1'b0, ADD);
        push(1); push(1); push(64'h1004);
        cycle();
        chk("tk_valid", 64'(exc.valid));
        chk("tk_cnt", 64'(cnt));
        chk("tk_tval", exc.tval);
        idle();

        // Mode 00: nothing detected
        do_reset();
        mode = 2'b00;
        set_port(0, 64'h1000, CTRL_FLOW, 1'b0, 32'h0000_8067);
        set_port(1, 64'h2000, ALU, 1'b0, ADD);
        push(0); push(0);
        cycle();
        chk("off_valid", 64'(exc.valid));
        chk("off_cnt", 64'(cnt));

        // Count-only saturation of the 4-bit counter
        do_reset();
        mode = 2'b01;
        set_port(0, 64'h1000, CTRL_FLOW, 1'b0, 32'h0000_8067);
        set_port(1, 64'h2000, ALU, 1'b0, ADD);
        for (int k = 0; k < 20; k++) begin
            push(0);
            cycle();
            chk("sat_valid4", 64'(exc4.valid));
        end
        push(4'hF); push(20); push(0);
        chk("sat_cnt4", 64'(cnt4));
        chk("sat_cnt16", 64'(cnt));
        chk("sat_valid16", 64'(exc.valid));
        idle();

        // Lock: sticky enforce+lock regardless of mode_i
        do_reset();
        mode = 2'b11;
        set_port(0, 64'h1000, CTRL_FLOW, 1'b0, 32'h0000_8067);
        set_port(1, 64'h2000, ALU, 1'b0, ADD);
        push(1); push(1); push(1);
        cycle();
        chk("lk_locked", 64'(locked));
        chk("lk_valid", 64'(exc.valid));
        chk("lk_cnt", 64'(cnt));
        idle();
        ex_ack = 1'b1;
        push(0); push(1);
        cycle();
        chk("lk_ack_valid", 64'(exc.valid));
        chk("lk_ack_locked", 64'(locked));
        idle();
        mode = 2'b00;
        set_port(0, 64'h3000, CTRL_FLOW, 1'b0, 32'h0000_8067);
        set_port(1, 64'h4000, ALU, 1'b0, ADD);
        push(1); push(2); push(4'hC);
        cycle();
        chk("lk2_valid", 64'(exc.valid));
        chk("lk2_cnt", 64'(cnt));
        chk("lk2_leds", 64'(leds));
        do_reset();
        push(0); push(0);
        chk("lk_rst_locked", 64'(locked));
        chk("lk_rst_valid", 64'(exc.valid));

        // Flush beats a violation in the same cycle
        mode = 2'b10;
        set_port(0, 64'h1000, CTRL_FLOW, 1'b0, 32'h0000_8067);
        push(4'b0010);
        cycle();
        chk("fl_expect", 64'(leds));
        idle();
        set_port(0, 64'h2000, ALU, 1'b0, ADD);
        flush = 1'b1;
        push(0); push(0); push(0);
        cycle();
        chk("fl_valid", 64'(exc.valid));
        chk("fl_cnt", 64'(cnt));
        chk("fl_leds", 64'(leds));
        idle();
        // Pending was dropped: a non-marker next cycle is not checked
        set_port(0, 64'h2000, ALU, 1'b0, ADD);
        push(0); push(0);
        cycle();
        chk("fl_drop_valid", 64'(exc.valid));
        chk("fl_drop_cnt", 64'(cnt));
        idle();

        if (exp_q.size() != 0) begin
            fail_cnt++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/cfi_landing_monitor.md
Name: cfi_landing_monitor

Overview:
- Commit-stream monitor for control-flow integrity.
- Watches up to NR_COMMIT_PORTS retiring instructions per cycle.
- Every taken control-flow transfer (JAL/JALR/branch whose successor PC is not the fall-through) must land on a marker NOP, i.e. ADDI x0,x0,imm with imm[11:4]==LABEL_TAG.
- Sits beside the commit stage: counts violations, drives debug LEDs and, in enforce mode, raises an exception to the commit stage's exception mux.

Parameters:
- NR_COMMIT_PORTS, 2, number of commit ports scanned in order per cycle (1..4)
- LABEL_TAG, 8'hA5, required imm[11:4] of the landing marker
- CNT_W, 16, width of the saturating violation counter
- CAUSE, 64'd24, exception cause reported on violation (custom cause range)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- flush_i  in  1  pipeline flush / exception taken; clears tracking state
- mode_i  in  2  from CSR: 00 off, 01 count-only, 10 enforce, 11 enforce+lock
- commit_instr_i  in  NR_COMMIT_PORTS x scoreboard_entry_t  commit candidates; uses pc, fu, is_compressed
- instr_bits_i  in  NR_COMMIT_PORTS x 32  raw instruction word per port
- commit_ack_i  in  NR_COMMIT_PORTS  port actually retires this cycle
- ex_ack_i  in  1  commit stage has taken the raised exception
- exception_o  out  exception_t  violation exception (valid, cause, tval)
- viol_cnt_o  out  CNT_W  saturating violation count
- locked_o  out  1  sticky lock flag (mode 11)
- leds_o  out  4  {locked, state==TRAP, state==EXPECT, viol_cnt[0]}

Behaviour:
- Reset (rst_i high at a clock edge): state IDLE, exception_o.valid=0, cause=0, tval=0, viol_cnt_o=0, locked_o=0, leds_o=0, saved pc/is_compressed=0.
- Ports are scanned 0..N-1; only ports with commit_ack_i=1 count, and the acked ports are contiguous from port 0.
- Port i is a CF source when fu==CTRL_FLOW. Record pc_src and fall-through = pc_src + (is_compressed ? 2 : 4), computed at VLEN width and wrapping modulo 2^VLEN.
- The next retired instruction after a CF source is its successor, on a later port in the same cycle or on the first acked port of a later cycle. Taken = successor.pc != fall-through.
- Marker: instr_bits[6:0]==7'b0010011, [14:12]==0, [11:7]==0, [19:15]==0, [31:24]==LABEL_TAG.
- Violation: taken and successor is not a marker. Not taken: no check.
- A successor that is itself CF is checked as a successor and then becomes the new source.
- States:
  - IDLE: no pending source.
  - EXPECT: source pending across the cycle boundary (last acked CF had no successor in the same cycle).
  - TRAP: exception_o held.
- Transitions:
  - IDLE/EXPECT -> EXPECT when the last acked port is a CF source.
  - IDLE/EXPECT -> IDLE when the last acked port is not a CF source.
  - Any state -> TRAP on a violation with mode_i[1]=1.
  - TRAP -> IDLE on ex_ack_i.
- Violations per cycle: only the first violating port counts. Further ports in that cycle are ignored.
- Violation detection is combinational. exception_o.valid is registered: it asserts the cycle after detection, with cause=CAUSE and tval=zero-extended successor pc. It stays high until the cycle after ex_ack_i.
- viol_cnt_o increments by 1 per violating cycle in modes 01/10/11 and saturates at all-ones. It is never cleared except by reset.
- Mode 00: no detection, no counting, state forced IDLE. exception_o is still held if already in TRAP.
- Mode 11: the first violation sets locked_o. While locked_o=1 the effective mode is 11 whatever mode_i is. Only reset clears it.
- flush_i: next state IDLE, pending source dropped. It does not clear a held exception unless ex_ack_i is also high.
- Simultaneous flush_i and a violation in the same cycle: flush wins, with no count and no exception (the instructions were squashed).
- mode_i changing while in EXPECT: the new mode applies to the pending check.

Decomposition:
- ariane_pkg additions: cfi_mode_e (OFF, COUNT, ENFORCE, LOCK), cfi_state_e (IDLE, EXPECT, TRAP), CFI_MARKER_OPCODE, CFI_CAUSE default.
- One sub-module, cfi_marker_decode: purely combinational, instr word -> is_marker. Instantiated per port.

Test Plan:
- Marker hit: mode 10; port0 JAL pc=0x8000_0000 (non-compressed), port1 pc=0x8000_0100 with ADDI x0,x0,0xA50 -> no exception, viol_cnt_o=0, state IDLE.
- Missing marker across cycles: mode 10; port0 JALR acked alone at pc=0x1000, next cycle port0 pc=0x2000 with ADD x1,x2,x3 -> exception_o.valid=1 one cycle later, cause=24, tval=0x2000, viol_cnt_o=1; held until ex_ack_i, deasserted the cycle after.
- Not-taken branch: compressed branch at pc=0x1000, successor pc=0x1002 without marker -> no violation; same with successor pc=0x1004 -> violation, viol_cnt_o=1.
- Count-only saturation: CNT_W=4, mode 01, 20 violating cycles -> viol_cnt_o=4'hF, exception_o.valid never 1.
- Lock: mode 11, one violation -> locked_o=1; set mode_i=00, another violation -> exception raised again and viol_cnt_o=2; rst_i -> locked_o=0.
- Flush priority: EXPECT pending, then flush_i with a non-marker successor in the same cycle -> no exception, no count, state IDLE.
